// File: rtl/ad56x3_pkg.sv
// AD56x3 3-wire DAC frame layout, command/address codes and receiver state
// encoding, shared between the DAC driver and the frame receiver.
package ad56x3_pkg;

   localparam int FRAME_WIDTH   = 24;
   localparam int CMD_MSB       = 21;
   localparam int CMD_LSB       = 19;
   localparam int ADDR_MSB      = 18;
   localparam int ADDR_LSB      = 16;
   localparam int DATA_MSB      = 15;
   localparam int BIT_CNT_WIDTH = 5;

   localparam logic [2:0] CMD_WRITE_IN  = 3'b000;
   localparam logic [2:0] CMD_WRITE_UPD = 3'b011;

   localparam logic [2:0] ADDR_A   = 3'b000;
   localparam logic [2:0] ADDR_B   = 3'b001;
   localparam logic [2:0] ADDR_ALL = 3'b111;

   typedef enum logic [1:0] {IDLE, WAIT, SHIFT, DONE} rxState_e;

   function automatic logic isWriteCmd(input logic [2:0] cmd);
      return (cmd == CMD_WRITE_IN) || (cmd == CMD_WRITE_UPD);
   endfunction

endpackage

// File: rtl/ad56x3_line_sync.sv
// Synchronizers for SYNC/SCLK/DIN plus edge events, masked until the
// synchronizer chain holds only real line samples after reset.
module ad56x3_line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic dacSync,
   input  logic dacSclk,
   input  logic dacDin,
   output logic syncS,
   output logic dinS,
   output logic sclkFall,
   output logic syncRise,
   output logic syncFall,
   output logic lineSettled
);

   logic [SYNC_STAGES-1:0] syncPipe;
   logic [SYNC_STAGES-1:0] sclkPipe;
   logic [SYNC_STAGES-1:0] dinPipe;
   logic                   syncPrev;
   logic                   sclkPrev;
   logic [SYNC_STAGES:0]   settlePipe;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         syncPipe   <= '1;
         sclkPipe   <= '1;
         dinPipe    <= '1;
         syncPrev   <= 1'b1;
         sclkPrev   <= 1'b1;
         settlePipe <= '0;
      end else begin
         syncPipe   <= {syncPipe[SYNC_STAGES-2:0], dacSync};
         sclkPipe   <= {sclkPipe[SYNC_STAGES-2:0], dacSclk};
         dinPipe    <= {dinPipe[SYNC_STAGES-2:0], dacDin};
         syncPrev   <= syncPipe[SYNC_STAGES-1];
         sclkPrev   <= sclkPipe[SYNC_STAGES-1];
         settlePipe <= {settlePipe[SYNC_STAGES-1:0], 1'b1};
      end
   end

   // The reset value of 1 would otherwise produce a false SYNC fall when
   // reset is released in the middle of a frame.
   assign lineSettled = settlePipe[SYNC_STAGES];
   assign syncS       = syncPipe[SYNC_STAGES-1];
   assign dinS        = dinPipe[SYNC_STAGES-1];
   assign sclkFall    = lineSettled & sclkPrev & ~sclkPipe[SYNC_STAGES-1];
   assign syncRise    = lineSettled & ~syncPrev & syncPipe[SYNC_STAGES-1];
   assign syncFall    = lineSettled & syncPrev & ~syncPipe[SYNC_STAGES-1];

endmodule

// File: rtl/ad56x3_frame_rx.sv
// AD56x3 responder: decodes SYNC/SCLK/DIN frames into command, address and
// per-channel samples, flagging frames truncated by an early SYNC rise.
//
// state | meaning
// IDLE  | after reset: wait for a settled high SYNC (drops partial frames)
// WAIT  | armed, wait for SYNC fall to start a frame
// SHIFT | shift DIN on each SCLK fall until 24 bits are held
// DONE  | frame decoded, ignore SCLK until SYNC returns high
module ad56x3_frame_rx
   import ad56x3_pkg::*;
#(
   parameter int    DATA_WIDTH  = 14,
   parameter string SIGN_A      = "UNSIGNED",
   parameter string SIGN_B      = "SIGNED",
   parameter int    SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  dacSync,
   input  logic                  dacSclk,
   input  logic                  dacDin,
   output logic                  frameVld,
   output logic [2:0]            frameCmd,
   output logic [2:0]            frameAddr,
   output logic [15:0]           frameData,
   output logic [DATA_WIDTH-1:0] dataA,
   output logic [DATA_WIDTH-1:0] dataB,
   output logic                  updA,
   output logic                  updB,
   output logic                  frameErr,
   output logic [15:0]           errCnt
);

   // Bits [23:22] are don't-care, so only the last 22 shifted bits are kept.
   localparam int SHIFT_WIDTH = CMD_MSB + 1;
   localparam logic [BIT_CNT_WIDTH-1:0] LAST_BIT = BIT_CNT_WIDTH'(FRAME_WIDTH);
   localparam logic [DATA_WIDTH-1:0] MSB_FLIP = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   localparam logic [DATA_WIDTH-1:0] FLIP_A = (SIGN_A == "SIGNED") ? MSB_FLIP : '0;
   localparam logic [DATA_WIDTH-1:0] FLIP_B = (SIGN_B == "SIGNED") ? MSB_FLIP : '0;

   logic syncS;
   logic dinS;
   logic sclkFall;
   logic syncRise;
   logic syncFall;
   logic lineSettled;

   ad56x3_line_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) lineSync (
      .clk        (clk),
      .reset      (reset),
      .dacSync    (dacSync),
      .dacSclk    (dacSclk),
      .dacDin     (dacDin),
      .syncS      (syncS),
      .dinS       (dinS),
      .sclkFall   (sclkFall),
      .syncRise   (syncRise),
      .syncFall   (syncFall),
      .lineSettled(lineSettled)
   );

   rxState_e                 state;
   logic [BIT_CNT_WIDTH-1:0] bitCnt;
   logic [SHIFT_WIDTH-1:0]   shiftReg;

   logic [2:0]            rxCmd;
   logic [2:0]            rxAddr;
   logic [DATA_WIDTH-1:0] rxSample;
   logic                  writeA;
   logic                  writeB;
   logic                  lastFallNow;

   assign rxCmd       = shiftReg[CMD_MSB:CMD_LSB];
   assign rxAddr      = shiftReg[ADDR_MSB:ADDR_LSB];
   assign rxSample    = shiftReg[DATA_MSB -: DATA_WIDTH];
   assign writeA      = isWriteCmd(rxCmd) && ((rxAddr == ADDR_A) || (rxAddr == ADDR_ALL));
   assign writeB      = isWriteCmd(rxCmd) && ((rxAddr == ADDR_B) || (rxAddr == ADDR_ALL));
   assign lastFallNow = sclkFall && (bitCnt == LAST_BIT - 1'b1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         bitCnt    <= '0;
         shiftReg  <= '0;
         frameVld  <= 1'b0;
         frameCmd  <= '0;
         frameAddr <= '0;
         frameData <= '0;
         dataA     <= '0;
         dataB     <= '0;
         updA      <= 1'b0;
         updB      <= 1'b0;
         frameErr  <= 1'b0;
         errCnt    <= '0;
      end else begin
         frameVld <= 1'b0;
         updA     <= 1'b0;
         updB     <= 1'b0;
         frameErr <= 1'b0;
         case (state)
            IDLE: begin
               if (lineSettled && syncS) state <= WAIT;
            end
            WAIT: begin
               if (syncFall) begin
                  bitCnt   <= '0;
                  shiftReg <= '0;
                  state    <= SHIFT;
               end
            end
            SHIFT: begin
               if (bitCnt == LAST_BIT) begin
                  state     <= DONE;
                  frameVld  <= 1'b1;
                  frameCmd  <= rxCmd;
                  frameAddr <= rxAddr;
                  frameData <= shiftReg[DATA_MSB:0];
                  if (writeA) begin
                     dataA <= rxSample ^ FLIP_A;
                     updA  <= 1'b1;
                  end
                  if (writeB) begin
                     dataB <= rxSample ^ FLIP_B;
                     updB  <= 1'b1;
                  end
               end else begin
                  if (sclkFall) begin
                     shiftReg <= {shiftReg[SHIFT_WIDTH-2:0], dinS};
                     bitCnt   <= bitCnt + 1'b1;
                  end
                  // A rise coinciding with the 24th fall still completes the frame.
                  if (syncRise && !lastFallNow) begin
                     state <= WAIT;
                     if (bitCnt != '0) begin
                        frameErr <= 1'b1;
                        if (errCnt != 16'hFFFF) errCnt <= errCnt + 16'd1;
                     end
                  end
               end
            end
            DONE: begin
               if (syncS) state <= WAIT;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ad56x3_frame_rx.sv
// Self-checking bench for ad56x3_frame_rx: table-driven frames plus
// hand-written truncation, reset-abort and overrun sequences.
module tb_ad56x3_frame_rx;

   typedef struct packed {
      logic [23:0] frame;
      logic [2:0]  cmd;
      logic [2:0]  addr;
      logic [15:0] data;
      logic        updA;
      logic        updB;
      logic [13:0] dataA;
      logic [13:0] dataB;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        dacSync = 1'b1;
   logic        dacSclk = 1'b1;
   logic        dacDin = 1'b0;
   logic        frameVld;
   logic [2:0]  frameCmd;
   logic [2:0]  frameAddr;
   logic [15:0] frameData;
   logic [13:0] dataA;
   logic [13:0] dataB;
   logic        updA;
   logic        updB;
   logic        frameErr;
   logic [15:0] errCnt;

   int   checks = 0;
   int   errors = 0;
   int   errPulses = 0;
   int   cyc = 0;
   int   fall24Cyc = 0;
   vec_t expQ[$];
   vec_t vecs[8];

   ad56x3_frame_rx #(
      .DATA_WIDTH (14),
      .SIGN_A     ("UNSIGNED"),
      .SIGN_B     ("SIGNED"),
      .SYNC_STAGES(2)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .dacSync  (dacSync),
      .dacSclk  (dacSclk),
      .dacDin   (dacDin),
      .frameVld (frameVld),
      .frameCmd (frameCmd),
      .frameAddr(frameAddr),
      .frameData(frameData),
      .dataA    (dataA),
      .dataB    (dataB),
      .updA     (updA),
      .updB     (updB),
      .frameErr (frameErr),
      .errCnt   (errCnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: each frameVld pops one expected record.
   always @(negedge clk) begin
      if (!reset) begin
         if (frameVld) begin
            if (expQ.size() == 0) begin
               check("unexpectedVld", 32'd1, 32'd0);
            end else begin
               vec_t e;
               e = expQ.pop_front();
               check("frameCmd", 32'(frameCmd), 32'(e.cmd));
               check("frameAddr", 32'(frameAddr), 32'(e.addr));
               check("frameData", 32'(frameData), 32'(e.data));
               check("updA", 32'(updA), 32'(e.updA));
               check("updB", 32'(updB), 32'(e.updB));
               check("dataA", 32'(dataA), 32'(e.dataA));
               check("dataB", 32'(dataB), 32'(e.dataB));
               check("latency", 32'(cyc - fall24Cyc), 32'd4);
            end
         end else if (updA || updB) begin
            check("updWithoutVld", {30'd0, updA, updB}, 32'd0);
         end
         if (frameErr) errPulses++;
      end
   end

   task automatic startFrame();
      @(negedge clk);
      dacSync = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic shiftBits(input logic [23:0] frame, input int first, input int count,
                            input bit riseOnLast);
      for (int i = first; i < first + count; i++) begin
         dacDin = (i < 24) ? frame[23 - i] : 1'b0;
         repeat (2) @(negedge clk);
         dacSclk = 1'b0;
         if (i == 23) fall24Cyc = cyc;
         if (riseOnLast && (i == first + count - 1)) dacSync = 1'b1;
         repeat (2) @(negedge clk);
         dacSclk = 1'b1;
      end
   endtask

   task automatic endFrame();
      repeat (2) @(negedge clk);
      dacSync = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic sendFrame(input logic [23:0] frame, input int nBits);
      startFrame();
      shiftBits(frame, 0, nBits, 1'b0);
      endFrame();
   endtask

   function automatic vec_t mkExp(input logic [23:0] f, input logic ua, input logic ub,
                                  input logic [13:0] a, input logic [13:0] b);
      vec_t v;
      v.frame = f;
      v.cmd   = f[21:19];
      v.addr  = f[18:16];
      v.data  = f[15:0];
      v.updA  = ua;
      v.updB  = ub;
      v.dataA = a;
      v.dataB = b;
      return v;
   endfunction

   initial begin
      vecs[0] = '{24'h18ABCC, 3'd3, 3'd0, 16'hABCC, 1'b1, 1'b0, 14'h2AF3, 14'h0000};
      vecs[1] = '{24'h198004, 3'd3, 3'd1, 16'h8004, 1'b0, 1'b1, 14'h2AF3, 14'h0001};
      vecs[2] = '{24'h1F4000, 3'd3, 3'd7, 16'h4000, 1'b1, 1'b1, 14'h1000, 14'h3000};
      vecs[3] = '{24'h100123, 3'd2, 3'd0, 16'h0123, 1'b0, 1'b0, 14'h1000, 14'h3000};
      vecs[4] = '{24'h00FFFF, 3'd0, 3'd0, 16'hFFFF, 1'b1, 1'b0, 14'h3FFF, 14'h3000};
      vecs[5] = '{24'hC9FFFC, 3'd1, 3'd1, 16'hFFFC, 1'b0, 1'b0, 14'h3FFF, 14'h3000};
      vecs[6] = '{24'hC10004, 3'd0, 3'd1, 16'h0004, 1'b0, 1'b1, 14'h3FFF, 14'h2001};
      vecs[7] = '{24'h1A0000, 3'd3, 3'd2, 16'h0000, 1'b0, 1'b0, 14'h3FFF, 14'h2001};

      repeat (3) @(negedge clk);
      check("rstFrameVld", 32'(frameVld), 32'd0);
      check("rstFrameCmd", 32'(frameCmd), 32'd0);
      check("rstFrameData", 32'(frameData), 32'd0);
      check("rstDataA", 32'(dataA), 32'd0);
      check("rstDataB", 32'(dataB), 32'd0);
      check("rstErrCnt", 32'(errCnt), 32'd0);
      check("rstPulses", {29'd0, updA, updB, frameErr}, 32'd0);
      reset = 1'b0;
      repeat (6) @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         expQ.push_back(vecs[i]);
         sendFrame(vecs[i].frame, 24);
      end

      // SYNC rises in the same clk as the 24th SCLK fall.
      expQ.push_back(mkExp(24'h18ABCC, 1'b1, 1'b0, 14'h2AF3, 14'h2001));
      startFrame();
      shiftBits(24'h18ABCC, 0, 24, 1'b1);
      repeat (10) @(negedge clk);

      // Truncated frame after 10 bits, then a good frame.
      startFrame();
      shiftBits(24'h198004, 0, 10, 1'b0);
      endFrame();
      check("errCntAfterTrunc", 32'(errCnt), 32'd1);
      check("errPulsesAfterTrunc", 32'(errPulses), 32'd1);
      expQ.push_back(mkExp(24'h198004, 1'b0, 1'b1, 14'h2AF3, 14'h0001));
      sendFrame(24'h198004, 24);

      // Reset in the middle of a frame; remainder must be discarded silently.
      startFrame();
      shiftBits(24'h1F4000, 0, 12, 1'b0);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("midRstDataA", 32'(dataA), 32'd0);
      check("midRstErrCnt", 32'(errCnt), 32'd0);
      reset = 1'b0;
      shiftBits(24'h1F4000, 12, 12, 1'b0);
      endFrame();
      check("postRstErrCnt", 32'(errCnt), 32'd0);
      check("postRstErrPulses", 32'(errPulses), 32'd1);
      expQ.push_back(mkExp(24'h18ABCC, 1'b1, 1'b0, 14'h2AF3, 14'h0000));
      sendFrame(24'h18ABCC, 24);

      // 26 SCLK falls in one window, then a non-write command.
      expQ.push_back(mkExp(24'h1F4000, 1'b1, 1'b1, 14'h1000, 14'h3000));
      sendFrame(24'h1F4000, 26);
      expQ.push_back(mkExp(24'h100123, 1'b0, 1'b0, 14'h1000, 14'h3000));
      sendFrame(24'h100123, 24);

      repeat (10) @(negedge clk);
      check("pendingFrames", 32'(expQ.size()), 32'd0);
      check("totalErrPulses", 32'(errPulses), 32'd1);
      check("finalErrCnt", 32'(errCnt), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
